// File: rtl/vred_pkg.sv
// Shared definitions for the vector reduction accumulator.
//   REDOP_*        reduction opcodes carried on in_redOp
//   SEW_*          element-width encodings carried on in_sew
//   vred_state_e   controller state encoding
//   redop_identity per-lane identity word for a given (op, sew)
//   lane_sel       expands the per-element mask into a 64-bit byte-lane select
package vred_pkg;

  localparam logic [2:0] REDOP_SUM  = 3'd0;
  localparam logic [2:0] REDOP_MAXU = 3'd1;
  localparam logic [2:0] REDOP_MAX  = 3'd2;
  localparam logic [2:0] REDOP_MINU = 3'd3;
  localparam logic [2:0] REDOP_MIN  = 3'd4;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FOLD  = 2'd2,
    ST_FINAL = 2'd3
  } vred_state_e;

  // Identity element replicated into every lane, so that an inactive lane
  // never changes the reduction result.
  function automatic logic [63:0] redop_identity(input logic [2:0] op, input logic [1:0] sew);
    logic [63:0] smin;
    case (sew)
      SEW_8:   smin = {8{8'h80}};
      SEW_16:  smin = {4{16'h8000}};
      SEW_32:  smin = {2{32'h8000_0000}};
      default: smin = {1'b1, 63'b0};
    endcase
    case (op)
      REDOP_MAX:  return smin;
      REDOP_MINU: return '1;
      REDOP_MIN:  return ~smin;
      default:    return '0;
    endcase
  endfunction

  // Mask bit i selects lane i; each lane is 8<<sew bits wide, so byte b
  // belongs to lane b>>sew.
  function automatic logic [63:0] lane_sel(input logic [7:0] m, input logic [1:0] sew);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      case (sew)
        SEW_8:   s[8*i +: 8] = {8{m[i]}};
        SEW_16:  s[8*i +: 8] = {8{m[i/2]}};
        SEW_32:  s[8*i +: 8] = {8{m[i/4]}};
        default: s[8*i +: 8] = {8{m[0]}};
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/vred_lane_op.sv
// SEW-partitioned two-operand reduction step (combinational).
//   a, b  64-bit operand words, split into 64/SEW independent lanes
//   sew   element width encoding
//   op    reduction opcode (sum wraps per lane, min/max signed or unsigned)
//   res   lane-wise op(a, b)
module vred_lane_op
  import vred_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [1:0]  sew,
  input  logic [2:0]  op,
  output logic [63:0] res
);

  logic        sgn;
  logic [63:0] r;

  // Lane value widened to 65 bits so one signed compare covers both the
  // signed and unsigned opcodes.
  function automatic logic signed [64:0] ext(input logic [63:0] v, input logic [1:0] w,
                                             input logic s);
    case (w)
      SEW_8:   return $signed({{57{s & v[7]}},  v[7:0]});
      SEW_16:  return $signed({{49{s & v[15]}}, v[15:0]});
      SEW_32:  return $signed({{33{s & v[31]}}, v[31:0]});
      default: return $signed({s & v[63], v});
    endcase
  endfunction

  function automatic logic signed [64:0] pick(input logic signed [64:0] x,
                                              input logic signed [64:0] y,
                                              input logic [2:0] o);
    case (o)
      REDOP_MAXU, REDOP_MAX: return (x > y) ? x : y;
      REDOP_MINU, REDOP_MIN: return (x < y) ? x : y;
      default:               return x + y;
    endcase
  endfunction

  assign sgn = (op == REDOP_MAX) || (op == REDOP_MIN);

  always_comb begin
    res = '0;
    r   = '0;
    case (sew)
      SEW_8:
        for (int i = 0; i < 8; i++) begin
          r = 64'(pick(ext({56'b0, a[8*i +: 8]}, sew, sgn), ext({56'b0, b[8*i +: 8]}, sew, sgn), op));
          res[8*i +: 8] = r[7:0];
        end
      SEW_16:
        for (int i = 0; i < 4; i++) begin
          r = 64'(pick(ext({48'b0, a[16*i +: 16]}, sew, sgn), ext({48'b0, b[16*i +: 16]}, sew, sgn), op));
          res[16*i +: 16] = r[15:0];
        end
      SEW_32:
        for (int i = 0; i < 2; i++) begin
          r = 64'(pick(ext({32'b0, a[32*i +: 32]}, sew, sgn), ext({32'b0, b[32*i +: 32]}, sew, sgn), op));
          res[32*i +: 32] = r[31:0];
        end
      default: begin
        r   = 64'(pick(ext(a, sew, sgn), ext(b, sew, sgn), op));
        res = r;
      end
    endcase
  end

endmodule

// File: rtl/vred_accum.sv
// Vector reduction accumulator: folds a stream of 64-bit beats into one
// scalar sum/max/min, seeded with vs1[0], and returns it with its tag.
//   clk, rst           clock; asynchronous active-low reset
//   in_vec..in_last    beat data and framing
//   in_elemMask        per-lane active mask (low 64/SEW bits used)
//   in_sew, in_redOp   element width and opcode, sampled on the first beat
//   in_scalar, in_addr seed and tag, sampled on the first beat
//   in_errClr          clears the sticky error flag
//   out_vec/out_valid  zero-extended result, one-cycle pulse
//   out_addr           tag of the reduction
//   out_busy           high while folding/finalising (no beats accepted)
//   out_err            sticky protocol error
module vred_accum
  import vred_pkg::*;
#(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int SEW_WIDTH      = 2,
  parameter int REDOP_WIDTH    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REQ_DATA_WIDTH-1:0] in_vec,
  input  logic                      in_valid,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [7:0]                in_elemMask,
  input  logic [SEW_WIDTH-1:0]      in_sew,
  input  logic [REDOP_WIDTH-1:0]    in_redOp,
  input  logic [63:0]               in_scalar,
  input  logic [REQ_ADDR_WIDTH-1:0] in_addr,
  input  logic                      in_errClr,
  output logic [63:0]               out_vec,
  output logic                      out_valid,
  output logic [REQ_ADDR_WIDTH-1:0] out_addr,
  output logic                      out_busy,
  output logic                      out_err
);

  vred_state_e               state, state_n;
  logic [63:0]               acc;
  logic [SEW_WIDTH-1:0]      cap_sew;
  logic [REDOP_WIDTH-1:0]    cap_op;
  logic [63:0]               cap_scalar;
  logic [REQ_ADDR_WIDTH-1:0] cap_addr;
  logic [1:0]                fold_cnt;

  logic [SEW_WIDTH-1:0]      beat_sew;
  logic [REDOP_WIDTH-1:0]    beat_op;
  logic [63:0]               beat_sel, beat_masked;
  logic                      take_first, take_accum, err_set, fold_last;
  vred_state_e               last_dst;
  logic [63:0]               op_b, lane_res;

  // A first beat carries its own sew/op; later beats use the captured ones.
  assign beat_sew    = in_first ? in_sew   : cap_sew;
  assign beat_op     = in_first ? in_redOp : cap_op;
  assign beat_sel    = lane_sel(in_elemMask, beat_sew);
  assign beat_masked = (in_vec & beat_sel) | (redop_identity(beat_op, beat_sew) & ~beat_sel);

  assign take_first = in_valid && in_first && (state == ST_IDLE || state == ST_ACCUM);
  assign take_accum = in_valid && !in_first && (state == ST_ACCUM);
  assign err_set    = in_valid && ((state == ST_FOLD) || (state == ST_FINAL) ||
                                   (state == ST_IDLE && !in_first) ||
                                   (state == ST_ACCUM && in_first));
  // FOLD runs 3-sew cycles; fold_cnt counts them from zero.
  assign fold_last  = (fold_cnt == (2'd2 - cap_sew));
  assign last_dst   = (beat_sew == SEW_64) ? ST_FINAL : ST_FOLD;

  // One lane-op instance: acc is always operand a; b is the new beat in
  // ACCUM, the upper half of the live region in FOLD, the seed in FINAL.
  always_comb begin
    op_b = beat_masked;
    case (state)
      ST_FOLD: begin
        case (fold_cnt)
          2'd0:    op_b = acc >> 32;
          2'd1:    op_b = acc >> 16;
          default: op_b = acc >> 8;
        endcase
      end
      ST_FINAL: op_b = cap_scalar;
      default:  op_b = beat_masked;
    endcase
  end

  vred_lane_op u_lane_op (
    .a   (acc),
    .b   (op_b),
    .sew (cap_sew),
    .op  (cap_op),
    .res (lane_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:
        if (take_first) state_n = in_last ? last_dst : ST_ACCUM;
      ST_ACCUM:
        if (take_first)                 state_n = in_last ? last_dst : ST_ACCUM;
        else if (take_accum && in_last) state_n = last_dst;
      ST_FOLD:
        if (fold_last) state_n = ST_FINAL;
      default:
        state_n = ST_IDLE;
    endcase
  end

  // Accumulate / fold stage -> registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      cap_sew    <= '0;
      cap_op     <= '0;
      cap_scalar <= '0;
      cap_addr   <= '0;
      fold_cnt   <= '0;
      out_vec    <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_busy   <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (take_first) begin
        acc        <= beat_masked;
        cap_sew    <= in_sew;
        cap_op     <= in_redOp;
        cap_scalar <= in_scalar;
        cap_addr   <= in_addr;
      end else if (take_accum || state == ST_FOLD) begin
        acc <= lane_res;
      end
      fold_cnt  <= (state == ST_FOLD) ? fold_cnt + 2'd1 : 2'd0;
      out_valid <= (state == ST_FINAL);
      if (state == ST_FINAL) begin
        out_vec  <= lane_res & lane_sel(8'h01, cap_sew);
        out_addr <= cap_addr;
      end
      out_busy <= (state_n == ST_FOLD) || (state_n == ST_FINAL);
      if (err_set)        out_err <= 1'b1;
      else if (in_errClr) out_err <= 1'b0;
    end
  end

endmodule
